// File: rtl/vend_session_controller_if.sv
// vend_session_controller_if: front-panel / dispense handshake bundle for the vend session controller.
interface vend_session_controller_if #(parameter int CREDIT_W = 6);
    logic [3:0]          item_number;
    logic                select;
    logic                nickel_in;
    logic                dime_in;
    logic                cancel;
    logic                dispense_ready;
    logic                dispense;
    logic                nickel_out;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output item_number, select, nickel_in, dime_in, cancel, dispense_ready,
        input  dispense, nickel_out, coin_reject, busy, credit
    );

    modport slave (
        input  item_number, select, nickel_in, dime_in, cancel, dispense_ready,
        output dispense, nickel_out, coin_reject, busy, credit
    );
endinterface

// File: rtl/vend_session_controller.sv
// vend_session_controller: selection/credit/vend/payout session sequencer.
// Define VEND_AUDIT_EN to add the 16-bit sales_count output.
module vend_session_controller #(
    parameter int CREDIT_W       = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic clock,
    input logic reset,
    vend_session_controller_if.slave bus
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0] sales_count
`endif
);
    localparam int PW = CREDIT_W > 5 ? CREDIT_W : 5;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, PAYOUT} state_t;

    state_t              state;
    logic [4:0]          price;
    logic [TW-1:0]       timer;
    logic [1:0]          coin_val;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] left;
    logic                coin;
    logic                fits;
    logic                paid;
    logic                timed_out;

    // The extra top bit of sum flags a coin that would overflow credit.
    always_comb begin
        coin_val  = {1'b0, bus.nickel_in} + {bus.dime_in, 1'b0};
        sum       = {1'b0, bus.credit} + (CREDIT_W+1)'(coin_val);
        coin      = coin_val != 2'd0;
        fits      = !sum[CREDIT_W];
        paid      = PW'(bus.credit) >= PW'(price);
        left      = CREDIT_W'(PW'(bus.credit) - PW'(price));
        timed_out = (TIMEOUT_CYCLES > 0) && (timer == T_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            price           <= '0;
            timer           <= '0;
            bus.credit      <= '0;
            bus.dispense    <= 1'b0;
            bus.nickel_out  <= 1'b0;
            bus.coin_reject <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef VEND_AUDIT_EN
            sales_count     <= '0;
`endif
        end else begin
            bus.dispense    <= 1'b0;
            bus.nickel_out  <= 1'b0;
            bus.coin_reject <= coin;
            unique case (state)
                IDLE: begin
                    bus.coin_reject <= coin && !fits;
                    if (coin && fits) bus.credit <= sum[CREDIT_W-1:0];
                    if (bus.select) begin
                        price <= 5'(bus.item_number) + 5'd1;
                        timer <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    bus.coin_reject <= coin && !fits;
                    if (coin && fits) bus.credit <= sum[CREDIT_W-1:0];
                    timer <= coin ? '0 : timer + 1'b1;
                    // Decisions use the registered credit; a coin on this edge still lands.
                    if (bus.cancel || timed_out) begin
                        state    <= PAYOUT;
                        bus.busy <= 1'b1;
                    end else if (paid) begin
                        state    <= VEND;
                        bus.busy <= 1'b1;
                    end
                end
                VEND: begin
                    if (bus.dispense_ready) begin
                        bus.dispense <= 1'b1;
                        bus.credit   <= left;
                        state        <= left != '0 ? PAYOUT : IDLE;
                        bus.busy     <= left != '0;
`ifdef VEND_AUDIT_EN
                        sales_count  <= sales_count + 16'd1;
`endif
                    end
                end
                PAYOUT: begin
                    if (bus.credit != '0) begin
                        bus.nickel_out <= 1'b1;
                        bus.credit     <= bus.credit - 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_session_controller.sv
// tb_vend_session_controller: directed plan scenarios plus random traffic against a rule-level model.
module tb_vend_session_controller;
    localparam int CW = 4;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    vend_session_controller_if #(.CREDIT_W(CW)) bus ();
`ifdef VEND_AUDIT_EN
    logic [15:0] sales_count;
`endif

    vend_session_controller #(.CREDIT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef VEND_AUDIT_EN
        ,
        .sales_count(sales_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int m_mode;
    int m_credit;
    int m_price;
    int m_quiet;
    int m_sales;
    int e_disp;
    int e_nout;
    int e_rej;
    int nout_seen;
    int disp_seen;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [3:0] item, bit sel, bit n, bit d, bit c, bit rdy);
        bus.item_number    = item;
        bus.select         = sel;
        bus.nickel_in      = n;
        bus.dime_in        = d;
        bus.cancel         = c;
        bus.dispense_ready = rdy;
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_credit = 0;
        m_price  = 0;
        m_quiet  = 0;
        m_sales  = 0;
        e_disp   = 0;
        e_nout   = 0;
        e_rej    = 0;
    endtask

    // Modes: 0 idle, 1 collecting, 2 waiting to vend, 3 paying out.
    task automatic model_step();
        int v = int'(bus.nickel_in) + 2 * int'(bus.dime_in);
        int old_credit = m_credit;
        int old_quiet = m_quiet;
        e_disp = 0;
        e_nout = 0;
        e_rej  = 0;
        if (m_mode <= 1) begin
            if (v > 0 && old_credit + v > (1 << CW) - 1) e_rej = 1;
            else m_credit = old_credit + v;
            if (m_mode == 0) begin
                if (bus.select) begin
                    m_price = int'(bus.item_number) + 1;
                    m_quiet = 0;
                    m_mode  = 1;
                end
            end else begin
                m_quiet = v > 0 ? 0 : old_quiet + 1;
                if (bus.cancel) m_mode = 3;
                else if (TO > 0 && old_quiet == TO - 1) m_mode = 3;
                else if (old_credit >= m_price) m_mode = 2;
            end
        end else begin
            e_rej = v > 0 ? 1 : 0;
            if (m_mode == 2) begin
                if (bus.dispense_ready) begin
                    e_disp   = 1;
                    m_sales  = (m_sales + 1) % 65536;
                    m_credit = m_credit - m_price;
                    m_mode   = m_credit > 0 ? 3 : 0;
                end
            end else if (m_credit > 0) begin
                e_nout   = 1;
                m_credit = m_credit - 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("credit", 32'(bus.credit), m_credit);
        chk("dispense", 32'(bus.dispense), e_disp);
        chk("nickel_out", 32'(bus.nickel_out), e_nout);
        chk("coin_reject", 32'(bus.coin_reject), e_rej);
        chk("busy", 32'(bus.busy), m_mode >= 2 ? 1 : 0);
`ifdef VEND_AUDIT_EN
        chk("sales_count", 32'(sales_count), m_sales);
`endif
        nout_seen += int'(bus.nickel_out);
        disp_seen += int'(bus.dispense);
    endtask

    task automatic idle(int n);
        drive(4'd0, 0, 0, 0, 0, 1);
        repeat (n) tick();
    endtask

    task automatic zero_outputs(string tag);
        chk({tag, "_credit"}, 32'(bus.credit), 0);
        chk({tag, "_dispense"}, 32'(bus.dispense), 0);
        chk({tag, "_nickel_out"}, 32'(bus.nickel_out), 0);
        chk({tag, "_coin_reject"}, 32'(bus.coin_reject), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        model_reset();
        drive(4'd0, 0, 0, 0, 0, 0);
        #3 zero_outputs("por");
        #9 reset = 1'b1;

        // Reset landing mid-collect throws away the credit with no payout.
        drive(4'd7, 1, 0, 0, 0, 0); tick();
        drive(4'd0, 0, 0, 1, 0, 0); tick();
        drive(4'd0, 0, 1, 0, 0, 0); tick();
        chk("s1_credit_before", 32'(bus.credit), 3);
        drive(4'd0, 0, 0, 0, 0, 0);
        #3 reset = 1'b0;
        #1 zero_outputs("s1_async");
        model_reset();
        #2 reset = 1'b1;
        nout_seen = 0;
        idle(4);
        chk("s1_no_payout", nout_seen, 0);

        // Price 5, credit 6: one vend, one nickel back.
        nout_seen = 0;
        disp_seen = 0;
        drive(4'd4, 1, 0, 0, 0, 1); tick();
        drive(4'd0, 0, 1, 0, 0, 1); tick();
        drive(4'd0, 0, 0, 1, 0, 1); tick();
        drive(4'd0, 0, 1, 0, 0, 1); tick();
        drive(4'd0, 0, 0, 1, 0, 1); tick();
        idle(5);
        chk("s2_dispense_count", disp_seen, 1);
        chk("s2_nickel_count", nout_seen, 1);
        chk("s2_idle", 32'(bus.busy), 0);
`ifdef VEND_AUDIT_EN
        chk("s2_sales", 32'(sales_count), 1);
`endif

        // Vend held until dispense_ready rises.
        nout_seen = 0;
        disp_seen = 0;
        drive(4'd0, 1, 0, 0, 0, 0); tick();
        drive(4'd0, 0, 0, 1, 0, 0); tick();
        drive(4'd0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        chk("s3_held_dispense", disp_seen, 0);
        chk("s3_held_busy", 32'(bus.busy), 1);
        idle(4);
        chk("s3_dispense_count", disp_seen, 1);
        chk("s3_nickel_count", nout_seen, 1);

        // Cancel refunds six nickels; a coin during payout is rejected.
        nout_seen = 0;
        disp_seen = 0;
        drive(4'd15, 1, 0, 0, 0, 1); tick();
        drive(4'd0, 0, 0, 1, 0, 1); tick();
        drive(4'd0, 0, 0, 1, 0, 1); tick();
        drive(4'd0, 0, 0, 1, 0, 1); tick();
        drive(4'd0, 0, 0, 0, 1, 1); tick();
        chk("s4_busy", 32'(bus.busy), 1);
        idle(1);
        drive(4'd0, 0, 1, 0, 0, 1); tick();
        chk("s4_payout_reject", 32'(bus.coin_reject), 1);
        chk("s4_payout_credit", 32'(bus.credit), 4);
        idle(8);
        chk("s4_nickel_count", nout_seen, 6);
        chk("s4_no_dispense", disp_seen, 0);

        // Timeout fires eight edges after the last coin.
        nout_seen = 0;
        drive(4'd9, 1, 0, 0, 0, 1); tick();
        drive(4'd0, 0, 1, 0, 0, 1); tick();
        idle(7);
        chk("s5_before_timeout", 32'(bus.busy), 0);
        idle(1);
        chk("s5_timeout_edge", 32'(bus.busy), 1);
        idle(3);
        chk("s5_nickel_count", nout_seen, 1);

        // Saturation at 15 nickels, then a cancelled session drains it.
        drive(4'd0, 0, 0, 1, 0, 1);
        repeat (7) tick();
        chk("s6_precredit", 32'(bus.credit), 14);
        tick();
        chk("s6_dime_reject", 32'(bus.coin_reject), 1);
        chk("s6_dime_credit", 32'(bus.credit), 14);
        drive(4'd0, 0, 1, 1, 0, 1); tick();
        chk("s6_both_reject", 32'(bus.coin_reject), 1);
        drive(4'd0, 0, 1, 0, 0, 1); tick();
        chk("s6_fill", 32'(bus.credit), 15);
        tick();
        chk("s6_full_reject", 32'(bus.coin_reject), 1);
        nout_seen = 0;
        drive(4'd15, 1, 0, 0, 0, 1); tick();
        drive(4'd0, 0, 0, 0, 1, 1); tick();
        idle(18);
        chk("s6_drain", nout_seen, 15);

        // Random traffic against the model.
        repeat (3000) begin
            drive(4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0, $urandom_range(0, 1) == 1);
            tick();
        end
        idle(40);
        chk("final_idle", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vend_session_controller.md
Name: vend_session_controller

Overview:
Session sequencer for the vending datapath. Latches an item selection and looks up its price. Accumulates nickel/dime credit, then hands off to the dispense mechanism through a ready handshake. Pays out change or a refund as serial one-cycle nickel_out pulses. Sits between the coin/selection front panel and the dispense mechanism; owns all credit state.

Parameters:
CREDIT_W, 6, credit register width in nickels (max credit 2^CREDIT_W-1)
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund; 0 disables timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
item_number  input  4  item code; sampled only when select=1 in IDLE
select  input  1  one-cycle pulse: latch item_number, start session
nickel_in  input  1  one-cycle pulse per nickel inserted (+1 credit)
dime_in  input  1  one-cycle pulse per dime inserted (+2 credit)
cancel  input  1  one-cycle pulse: abort session, refund credit
dispense_ready  input  1  dispense mechanism can accept a vend
dispense  output  1  one-cycle vend strobe
nickel_out  output  1  one-cycle pulse per nickel returned
coin_reject  output  1  one-cycle pulse: the coin sampled on the previous edge was not credited
busy  output  1  high in VEND and PAYOUT
credit  output  CREDIT_W  current credit in nickels

Behaviour:
- Reset (reset=0, async): state=IDLE; credit=0; price=0; timer=0; dispense, nickel_out, coin_reject=0. Credit in flight is discarded; no payout.
- Price = item_number+1 nickels (1..16). Latched as a 5-bit value at select.
- Coin value per edge = nickel_in + 2*dime_in. Both coins in the same cycle add 3.
- Saturation: if credit+value > 2^CREDIT_W-1, credit is unchanged and coin_reject pulses.
- IDLE:
  - Coins are added to credit (pre-credit allowed).
  - select=1: latch price, clear timer, go to COLLECT.
- COLLECT:
  - Coins are added to credit. Any coin clears the timer; otherwise the timer increments.
  - Later select pulses are ignored; the item is locked.
  - Priority, highest first: cancel -> PAYOUT; timer==TIMEOUT_CYCLES-1 (when TIMEOUT_CYCLES>0) -> PAYOUT; registered credit >= price -> VEND.
  - A coin on a transition edge is still credited.
  - Compare uses registered credit. VEND is entered the edge after credit reaches price.
- VEND:
  - Waits indefinitely for dispense_ready=1.
  - On that edge: dispense<=1 (high exactly one cycle); credit<=credit-price; next state PAYOUT if the result is >0, else IDLE.
- PAYOUT:
  - Each edge with credit>0: nickel_out<=1 and credit<=credit-1.
  - When credit==0: nickel_out<=0, go to IDLE.
  - N nickels of credit give N consecutive nickel_out cycles.
- VEND/PAYOUT:
  - Coins are not credited; coin_reject pulses on the next cycle.
  - cancel and select are ignored.
- All outputs are registered. credit width arithmetic uses a CREDIT_W+1 intermediate to detect overflow.

Optional Feature:
VEND_AUDIT_EN:
- Defined: adds output port sales_count (16 bits). It increments on every dispense pulse, wraps 0xFFFF->0, and is cleared only by reset.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
1. reset low mid-COLLECT with credit=3 -> credit=0, state IDLE, no nickel_out pulses, all outputs 0.
2. item_number=4, select, then nickel, dime, nickel, dime on consecutive cycles, dispense_ready=1 -> credit reaches 6 >= price 5, VEND entered, dispense one pulse, credit 1, exactly one nickel_out pulse, back to IDLE.
3. item_number=0, select, dime, dispense_ready held 0 for 5 cycles then 1 -> dispense is held off until ready rises, then one dispense pulse and one nickel_out.
4. item_number=15, select, three dimes (credit 6), cancel -> six consecutive nickel_out pulses, no dispense, IDLE.
5. TIMEOUT_CYCLES=8, select, one nickel, then no input -> PAYOUT entered 8 cycles after the coin, one nickel_out.
6. CREDIT_W=3, credit 6, dime_in -> coin_reject pulses and credit stays 6. A coin during PAYOUT -> coin_reject pulses and credit is unaffected. With VEND_AUDIT_EN, sales_count reads 1 after scenario 2.
